// File: rtl/sram_like_if.sv
// One sram-like port: request fields plus addr_ok/data_ok handshakes and read data.
// The master drives the request and the slave answers it.
interface sram_like_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one downstream sram-like port between the inst and data masters.
// An in-order ID FIFO routes each downstream response back to the master that issued it.
module sram_like_arbiter #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   sram_like_if.slave       inst,
   sram_like_if.slave       data,
   sram_like_if.master      m,
   output logic [CNT_W-1:0] outstanding
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic {
      SRC_INST = 1'b0,
      SRC_DATA = 1'b1
   } src_e;

   logic             lock;
   src_e             owner;
   src_e             sel;
   logic             sel_req;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;
   src_e             id_q [DEPTH];
   src_e             head;

   assign full  = (cnt == CNT_W'(DEPTH));
   assign empty = (cnt == '0);

   // A locked grant is held until accepted so the downstream never sees the fields switch.
   assign sel     = lock ? owner : (data.req ? SRC_DATA : SRC_INST);
   assign sel_req = (sel == SRC_DATA) ? data.req : inst.req;

   assign m.req   = sel_req && !full;
   assign m.wr    = (sel == SRC_DATA) ? data.wr    : inst.wr;
   assign m.size  = (sel == SRC_DATA) ? data.size  : inst.size;
   assign m.wstrb = (sel == SRC_DATA) ? data.wstrb : inst.wstrb;
   assign m.addr  = (sel == SRC_DATA) ? data.addr  : inst.addr;
   assign m.wdata = (sel == SRC_DATA) ? data.wdata : inst.wdata;

   assign push = m.req && m.addr_ok;
   assign pop  = m.data_ok && !empty;
   assign head = id_q[rd_ptr];

   assign inst.addr_ok = push && (sel == SRC_INST);
   assign data.addr_ok = push && (sel == SRC_DATA);
   assign inst.data_ok = pop && (head == SRC_INST);
   assign data.data_ok = pop && (head == SRC_DATA);
   assign inst.rdata   = m.rdata;
   assign data.rdata   = m.rdata;

   assign outstanding = cnt;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         lock  <= 1'b0;
         owner <= SRC_INST;
      end else if (m.req) begin
         lock <= !m.addr_ok;
         if (!m.addr_ok) owner <= sel;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // NOTE: ID storage has no reset; an entry is only read after it has been written, which cnt guarantees.
   always_ff @(posedge clk) begin
      if (push) id_q[wr_ptr] <= sel;
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: arbitration, lock, FIFO routing, full, spurious data_ok, reset.
module tb_sram_like_arbiter;

   logic       clk;
   logic       reset;
   logic [2:0] outstanding;
   int         checks;
   int         failures;

   sram_like_if inst_bus ();
   sram_like_if data_bus ();
   sram_like_if m_bus ();

   sram_like_arbiter #(.DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .inst        (inst_bus),
      .data        (data_bus),
      .m           (m_bus),
      .outstanding (outstanding)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check_idle_pulses(input string tag);
      check({tag, "_inst_aok"}, inst_bus.addr_ok, 1'b0);
      check({tag, "_data_aok"}, data_bus.addr_ok, 1'b0);
      check({tag, "_inst_dok"}, inst_bus.data_ok, 1'b0);
      check({tag, "_data_dok"}, data_bus.data_ok, 1'b0);
   endtask

   // One response cycle: returns rdata and checks which master gets data_ok.
   task automatic respond(input string tag, input logic [31:0] rd, input logic to_data);
      m_bus.data_ok = 1'b1;
      m_bus.rdata   = rd;
      settle();
      check({tag, "_inst_dok"}, inst_bus.data_ok, !to_data);
      check({tag, "_data_dok"}, data_bus.data_ok, to_data);
      if (to_data) check({tag, "_data_rdata"}, data_bus.rdata, rd);
      else         check({tag, "_inst_rdata"}, inst_bus.rdata, rd);
      cycle();
      m_bus.data_ok = 1'b0;
   endtask

   task automatic accept_one(input string tag, input logic is_data, input logic [31:0] a);
      if (is_data) begin data_bus.req = 1'b1; data_bus.addr = a; end
      else         begin inst_bus.req = 1'b1; inst_bus.addr = a; end
      m_bus.addr_ok = 1'b1;
      settle();
      check({tag, "_maddr"}, m_bus.addr, a);
      if (is_data) check({tag, "_aok"}, data_bus.addr_ok, 1'b1);
      else         check({tag, "_aok"}, inst_bus.addr_ok, 1'b1);
      cycle();
      inst_bus.req  = 1'b0;
      data_bus.req  = 1'b0;
      m_bus.addr_ok = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.size = 2'd2;
      inst_bus.wstrb = 4'h0; inst_bus.addr = '0; inst_bus.wdata = '0;
      data_bus.req = 1'b0; data_bus.wr = 1'b1; data_bus.size = 2'd1;
      data_bus.wstrb = 4'h3; data_bus.addr = '0; data_bus.wdata = 32'hCAFE_0000;
      m_bus.addr_ok = 1'b0; m_bus.data_ok = 1'b0; m_bus.rdata = '0;
      cycle();
      cycle();
      reset = 1'b0;
      settle();

      // Reset state
      check("rst_outstanding", outstanding, 3'd0);
      check("rst_mreq", m_bus.req, 1'b0);
      check_idle_pulses("rst");

      // Both request together: data wins, inst next cycle
      inst_bus.req = 1'b1; inst_bus.addr = 32'h0000_1000;
      data_bus.req = 1'b1; data_bus.addr = 32'h0000_2000;
      m_bus.addr_ok = 1'b1;
      settle();
      check("both_mreq", m_bus.req, 1'b1);
      check("both_maddr", m_bus.addr, 32'h0000_2000);
      check("both_mwr", m_bus.wr, 1'b1);
      check("both_mwstrb", m_bus.wstrb, 4'h3);
      check("both_data_aok", data_bus.addr_ok, 1'b1);
      check("both_inst_aok", inst_bus.addr_ok, 1'b0);
      cycle();
      data_bus.req = 1'b0;
      settle();
      check("both2_maddr", m_bus.addr, 32'h0000_1000);
      check("both2_msize", m_bus.size, 2'd2);
      check("both2_inst_aok", inst_bus.addr_ok, 1'b1);
      check("both2_data_aok", data_bus.addr_ok, 1'b0);
      cycle();
      inst_bus.req = 1'b0; m_bus.addr_ok = 1'b0;
      settle();
      check("both_outstanding", outstanding, 3'd2);
      respond("both_r0", 32'h0000_00AA, 1'b1);
      respond("both_r1", 32'h0000_00BB, 1'b0);
      check("both_drained", outstanding, 3'd0);

      // Lock: inst stalled 3 cycles, data rises in cycle 2
      inst_bus.req = 1'b1; inst_bus.addr = 32'h0000_3000;
      settle();
      check("lock_c1_maddr", m_bus.addr, 32'h0000_3000);
      check("lock_c1_inst_aok", inst_bus.addr_ok, 1'b0);
      cycle();
      data_bus.req = 1'b1; data_bus.addr = 32'h0000_4000;
      settle();
      check("lock_c2_maddr", m_bus.addr, 32'h0000_3000);
      check("lock_c2_data_aok", data_bus.addr_ok, 1'b0);
      cycle();
      m_bus.addr_ok = 1'b1;
      settle();
      check("lock_c3_maddr", m_bus.addr, 32'h0000_3000);
      check("lock_c3_inst_aok", inst_bus.addr_ok, 1'b1);
      check("lock_c3_data_aok", data_bus.addr_ok, 1'b0);
      cycle();
      inst_bus.req = 1'b0;
      settle();
      check("lock_c4_maddr", m_bus.addr, 32'h0000_4000);
      check("lock_c4_data_aok", data_bus.addr_ok, 1'b1);
      cycle();
      data_bus.req = 1'b0; m_bus.addr_ok = 1'b0;
      respond("lock_r0", 32'h0000_0001, 1'b0);
      respond("lock_r1", 32'h0000_0002, 1'b1);

      // Full: four accepts block the fifth until a response frees a slot
      inst_bus.req = 1'b1; inst_bus.addr = 32'h0000_5000; m_bus.addr_ok = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      settle();
      check("full_outstanding", outstanding, 3'd4);
      check("full_mreq", m_bus.req, 1'b0);
      check("full_inst_aok", inst_bus.addr_ok, 1'b0);
      m_bus.data_ok = 1'b1; m_bus.rdata = 32'h0000_0055;
      settle();
      check("full_pop_inst_dok", inst_bus.data_ok, 1'b1);
      cycle();
      m_bus.data_ok = 1'b0;
      settle();
      check("full_after_pop", outstanding, 3'd3);
      check("full_unblock_mreq", m_bus.req, 1'b1);
      check("full_unblock_aok", inst_bus.addr_ok, 1'b1);
      cycle();
      inst_bus.req = 1'b0; m_bus.addr_ok = 1'b0;
      settle();
      check("full_refill", outstanding, 3'd4);
      for (int i = 0; i < 4; i++) respond("full_drain", 32'h0000_0100 + i, 1'b0);
      check("full_drained", outstanding, 3'd0);

      // Ordering inst, data, inst
      accept_one("ord_a0", 1'b0, 32'h0000_6000);
      accept_one("ord_a1", 1'b1, 32'h0000_6004);
      accept_one("ord_a2", 1'b0, 32'h0000_6008);
      respond("ord_r0", 32'h0000_0011, 1'b0);
      respond("ord_r1", 32'h0000_0022, 1'b1);
      respond("ord_r2", 32'h0000_0033, 1'b0);

      // Simultaneous push and pop at outstanding=2
      accept_one("sim_a0", 1'b0, 32'h0000_7000);
      accept_one("sim_a1", 1'b1, 32'h0000_7004);
      inst_bus.req = 1'b1; inst_bus.addr = 32'h0000_7008; m_bus.addr_ok = 1'b1;
      m_bus.data_ok = 1'b1; m_bus.rdata = 32'h0000_0077;
      settle();
      check("sim_inst_aok", inst_bus.addr_ok, 1'b1);
      check("sim_inst_dok", inst_bus.data_ok, 1'b1);
      check("sim_data_dok", data_bus.data_ok, 1'b0);
      cycle();
      inst_bus.req = 1'b0; m_bus.addr_ok = 1'b0; m_bus.data_ok = 1'b0;
      settle();
      check("sim_outstanding", outstanding, 3'd2);
      respond("sim_r1", 32'h0000_0078, 1'b1);
      respond("sim_r2", 32'h0000_0079, 1'b0);

      // Spurious data_ok while empty
      m_bus.data_ok = 1'b1; m_bus.rdata = 32'hDEAD_BEEF;
      settle();
      check_idle_pulses("spur");
      cycle();
      m_bus.data_ok = 1'b0;
      settle();
      check("spur_outstanding", outstanding, 3'd0);
      accept_one("spur_a0", 1'b1, 32'h0000_8000);
      respond("spur_r0", 32'h0000_0088, 1'b1);

      // Reset mid-operation with outstanding=3 and lock held for inst
      accept_one("mid_a0", 1'b0, 32'h0000_9000);
      accept_one("mid_a1", 1'b0, 32'h0000_9004);
      accept_one("mid_a2", 1'b0, 32'h0000_9008);
      inst_bus.req = 1'b1; inst_bus.addr = 32'h0000_900C;
      cycle();
      settle();
      check("mid_outstanding", outstanding, 3'd3);
      reset = 1'b1; inst_bus.req = 1'b0;
      cycle();
      reset = 1'b0;
      settle();
      check("mid_rst_outstanding", outstanding, 3'd0);
      data_bus.req = 1'b1; data_bus.addr = 32'h0000_A000; m_bus.addr_ok = 1'b1;
      settle();
      check("mid_data_mreq", m_bus.req, 1'b1);
      check("mid_data_maddr", m_bus.addr, 32'h0000_A000);
      check("mid_data_aok", data_bus.addr_ok, 1'b1);
      cycle();
      data_bus.req = 1'b0; m_bus.addr_ok = 1'b0;
      respond("mid_r0", 32'h0000_00A0, 1'b1);
      check("final_outstanding", outstanding, 3'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
